// File: rtl/offset_adjust_pipe_if.sv
// Operand/result stream bundle for the offset-adjust pipe.
// master = producer/consumer side (testbench or neighbours), slave = the pipe.
interface offset_adjust_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/offset_adjust_pipe.sv
// Two-stage offset-adjust unit (x+K, K-1-x, K-x, x-K) with optional clamping,
// valid/ready flow control and a saturating count of clamped results.
module offset_adjust_pipe #(
  parameter int WIDTH    = 16,
  parameter int OFFSET_K = 2,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  offset_adjust_pipe_if.slave   bus,
  input  logic                  sat_clr,
  output logic [CNT_W-1:0]      sat_cnt
);

  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] K_EXT = EW'(OFFSET_K);
  localparam logic signed [EW-1:0] K_M1  = EW'(OFFSET_K - 1);

  logic signed [EW-1:0] x_ext;
  logic signed [EW-1:0] sum_d;
  logic signed [EW-1:0] s1_sum;
  logic                 s1_valid;
  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_data;
  logic                 s2_sat;
  logic                 s1_load;
  logic                 s2_load;
  logic [WIDTH-1:0]     res_d;
  logic                 sat_d;

  assign x_ext = EW'($signed(bus.in_data));

  always_comb begin
    sum_d = '0;
    unique case (bus.in_mode)
      2'b00:   sum_d = x_ext + K_EXT;
      2'b01:   sum_d = K_M1 - x_ext;
      2'b10:   sum_d = K_EXT - x_ext;
      default: sum_d = x_ext - K_EXT;
    endcase
  end

  // S2 frees up when it is empty or draining; S1 follows S2.
  assign s2_load     = !s2_valid || bus.out_ready;
  assign s1_load     = !s1_valid || s2_load;
  assign bus.in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_sum <= sum_d;
    end
  end

  generate
    if (SATURATE) begin : g_sat
      logic [2:0] top;
      assign top = s1_sum[EW-1:WIDTH-1];
      // The exact sum fits in WIDTH bits only when its top three bits agree.
      always_comb begin
        res_d = s1_sum[WIDTH-1:0];
        sat_d = 1'b0;
        if (top != 3'b000 && top != 3'b111) begin
          sat_d = 1'b1;
          res_d = s1_sum[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
    end else begin : g_wrap
      always_comb begin
        res_d = s1_sum[WIDTH-1:0];
        sat_d = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res_d;
        s2_sat  <= sat_d;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sat   = s2_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (s2_valid && bus.out_ready && s2_sat && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_offset_adjust_pipe.sv
// Bench for offset_adjust_pipe: clamping instance with scoreboard plus a wrapping instance.
module tb_offset_adjust_pipe;

  logic        clk;
  logic        rst_n;
  logic        sat_clr_a;
  logic        sat_clr_b;
  logic [15:0] sat_cnt_a;
  logic [15:0] sat_cnt_b;
  int          cyc;
  int          n_assert;
  int          n_fail;
  int          mcnt;
  bit          lat_chk;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t q[$];

  offset_adjust_pipe_if #(.WIDTH(16)) ia ();
  offset_adjust_pipe_if #(.WIDTH(16)) ib ();

  offset_adjust_pipe #(.WIDTH(16), .OFFSET_K(2), .SATURATE(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia), .sat_clr(sat_clr_a), .sat_cnt(sat_cnt_a)
  );

  offset_adjust_pipe #(.WIDTH(16), .OFFSET_K(2), .SATURATE(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib), .sat_clr(sat_clr_b), .sat_cnt(sat_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent golden model in plain integer arithmetic, K = 2.
  function automatic exp_t model(input logic [15:0] x, input logic [1:0] m, input bit sat_en);
    exp_t e;
    int   xi;
    int   r;
    xi = int'($signed(x));
    case (m)
      2'd0:    r = xi + 2;
      2'd1:    r = 1 - xi;
      2'd2:    r = 2 - xi;
      default: r = xi - 2;
    endcase
    e.sat = 1'b0;
    if (sat_en && r > 32767) begin
      r = 32767;
      e.sat = 1'b1;
    end else if (sat_en && r < -32768) begin
      r = -32768;
      e.sat = 1'b1;
    end
    e.data = r[15:0];
    e.cyc  = 0;
    return e;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    exp_t p;
    bit   popped;
    popped = 1'b0;
    if (rst_n) begin
      chk("sat_cnt_track", 32'(sat_cnt_a), 32'(mcnt));
      if (ia.out_valid && ia.out_ready) begin
        n_assert++;
        assert (q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_out: observed output 0x%0h, expected no output", ia.out_data);
        end
        if (q.size() != 0) begin
          p = q.pop_front();
          popped = 1'b1;
          chk("sb_data", 32'(ia.out_data), 32'(p.data));
          chk("sb_sat", 32'(ia.out_sat), 32'(p.sat));
          if (lat_chk) chk("sb_latency", 32'(cyc), 32'(p.cyc + 2));
        end
      end
      if (sat_clr_a) mcnt = 0;
      else if (popped && p.sat && mcnt != 65535) mcnt++;
      if (ia.in_valid && ia.in_ready) begin
        e = model(ia.in_data, ia.in_mode, 1'b1);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [1:0] m);
    bit done;
    done = 1'b0;
    ia.in_valid = 1'b1;
    ia.in_data  = x;
    ia.in_mode  = m;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      done = ia.in_ready;
      @(posedge clk);
      #1;
    end
    ia.in_valid = 1'b0;
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [15:0] d, input logic s);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(ia.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(ia.out_data), 32'(d));
    chk({tag, "_sat"}, 32'(ia.out_sat), 32'(s));
  endtask

  task automatic drain();
    ia.out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  logic [15:0] edge_v [4];
  int          sent;

  initial begin
    n_assert = 0;
    n_fail = 0;
    mcnt = 0;
    lat_chk = 1'b0;
    sent = 0;
    edge_v[0] = 16'h7FFF;
    edge_v[1] = 16'h7FFE;
    edge_v[2] = 16'h8000;
    edge_v[3] = 16'h8001;
    rst_n = 1'b0;
    sat_clr_a = 1'b0;
    sat_clr_b = 1'b0;
    ia.in_valid = 1'b0;
    ia.in_data = '0;
    ia.in_mode = '0;
    ia.out_ready = 1'b1;
    ib.in_valid = 1'b0;
    ib.in_data = '0;
    ib.in_mode = '0;
    ib.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("rst_out_data", 32'(ia.out_data), 32'd0);
    chk("rst_out_sat", 32'(ia.out_sat), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt_a), 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ia.in_ready), 32'd1);

    // Wrapping instance: legacy ~x+2 behaviour, no clamp, no count.
    ib.in_valid = 1'b1; ib.in_data = 16'h8000; ib.in_mode = 2'b01;
    @(posedge clk); #1;
    ib.in_data = 16'h7FFF; ib.in_mode = 2'b00;
    @(posedge clk); #1;
    ib.in_valid = 1'b0;
    chk("wrap1_valid", 32'(ib.out_valid), 32'd1);
    chk("wrap1_data", 32'(ib.out_data), 32'h8001);
    chk("wrap1_sat", 32'(ib.out_sat), 32'd0);
    @(posedge clk); #1;
    chk("wrap2_data", 32'(ib.out_data), 32'h8001);
    chk("wrap2_sat", 32'(ib.out_sat), 32'd0);
    @(posedge clk); #1;
    chk("wrap_sat_cnt", 32'(sat_cnt_b), 32'd0);
    chk("wrap_idle", 32'(ib.out_valid), 32'd0);

    // Basic modes, no stall.
    lat_chk = 1'b1;
    send(16'h0005, 2'b01); expect_out("m01", 16'hFFFC, 1'b0);
    send(16'h0005, 2'b10); expect_out("m10", 16'hFFFD, 1'b0);
    send(16'h0003, 2'b00); expect_out("m00", 16'h0005, 1'b0);
    send(16'h0003, 2'b11); expect_out("m11", 16'h0001, 1'b0);
    drain();

    send(16'h7FFF, 2'b00); expect_out("sat_hi", 16'h7FFF, 1'b1);
    send(16'h8000, 2'b11); expect_out("sat_lo", 16'h8000, 1'b1);
    send(16'h8000, 2'b01); expect_out("sat_m01", 16'h7FFF, 1'b1);
    drain();
    @(posedge clk); #1;
    chk("sat_cnt_3", 32'(sat_cnt_a), 32'd3);

    send(16'h7FFF, 2'b00);
    @(posedge clk); #1;
    chk("clr_out_sat", 32'(ia.out_sat), 32'd1);
    sat_clr_a = 1'b1;
    @(posedge clk); #1;
    sat_clr_a = 1'b0;
    chk("clr_wins", 32'(sat_cnt_a), 32'd0);
    drain();

    // Backpressure: A accepted, B accepted, C held.
    lat_chk = 1'b0;
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_data = 16'd1; ia.in_mode = 2'b00;
    #1 chk("bp_ready_a", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    ia.in_data = 16'd2;
    #1 chk("bp_ready_b", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    ia.in_data = 16'd3;
    #1 chk("bp_ready_c", 32'(ia.in_ready), 32'd0);
    chk("bp_valid", 32'(ia.out_valid), 32'd1);
    chk("bp_data_a", 32'(ia.out_data), 32'd3);
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_ready", 32'(ia.in_ready), 32'd0);
      chk("bp_hold_data", 32'(ia.out_data), 32'd3);
    end
    ia.out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(ia.in_ready), 32'd1);
    @(posedge clk); #1;
    ia.in_valid = 1'b0;
    chk("bp_out_b_valid", 32'(ia.out_valid), 32'd1);
    chk("bp_out_b", 32'(ia.out_data), 32'd4);
    @(posedge clk); #1;
    chk("bp_out_c", 32'(ia.out_data), 32'd5);
    @(posedge clk); #1;
    chk("bp_empty", 32'(ia.out_valid), 32'd0);
    drain();

    // Random streaming with random backpressure; mode changes while idle too.
    for (int i = 0; i < 5000 && sent < 100; i++) begin
      ia.in_valid  = ($urandom_range(0, 3) != 0);
      ia.in_mode   = 2'($urandom_range(0, 3));
      ia.in_data   = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
      ia.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (ia.in_valid && ia.in_ready) sent++;
      @(posedge clk); #1;
    end
    ia.in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd100);
    drain();
    @(posedge clk); #1;
    chk("stream_sat_cnt", 32'(sat_cnt_a), 32'(mcnt));

    // Reset with both stages full.
    send(16'h7FFF, 2'b00);
    drain();
    ia.out_ready = 1'b0;
    send(16'd10, 2'b00);
    send(16'd11, 2'b00);
    chk("full_in_ready", 32'(ia.in_ready), 32'd0);
    chk("full_out_valid", 32'(ia.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ia.out_valid), 32'd0);
    chk("mid_rst_sat_cnt", 32'(sat_cnt_a), 32'd0);
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    ia.out_ready = 1'b1;
    lat_chk = 1'b1;
    send(16'd3, 2'b10);
    expect_out("post_rst", 16'hFFFF, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
